// File: rtl/serdes_pkg.sv
// Definitions shared by the serializer and its downstream deserializer partner.
package serdes_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  localparam int SERDES_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: sends the top data_mod_i bits (all bits when 0), MSB first.
//   state | meaning
//   IDLE  | outputs quiet, next data_val_i is captured
//   SEND  | one bit per cycle leaves shreg[W-1], counter counts bits remaining
module serializer
  import serdes_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = SERDES_DEFAULT_WIDTH,
  parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH),
  parameter int COUNTER_SIZE   = $clog2(DATA_BUS_WIDTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam logic [COUNTER_SIZE-1:0] FULL_LEN = COUNTER_SIZE'(DATA_BUS_WIDTH);

  ser_state_t                state;
  logic [DATA_BUS_WIDTH-1:0] shreg;
  logic [COUNTER_SIZE-1:0]   cnt;
  logic [COUNTER_SIZE-1:0]   mod_ext;
  logic [COUNTER_SIZE-1:0]   req_len;

  // Zero selects the full word; oversize counts (non-power-of-2 widths) clamp to full.
  always_comb begin
    mod_ext = COUNTER_SIZE'(data_mod_i);
    req_len = mod_ext;
    if (mod_ext == '0 || mod_ext > FULL_LEN) req_len = FULL_LEN;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_data_o     <= 1'b0;
          ser_data_val_o <= 1'b0;
          busy_o         <= 1'b0;
          if (data_val_i) begin
            shreg <= data_i;
            cnt   <= req_len;
            state <= SEND;
          end
        end
        SEND: begin
          // Requests arriving here are dropped; the caller watches busy_o.
          ser_data_o     <= shreg[DATA_BUS_WIDTH-1];
          ser_data_val_o <= 1'b1;
          busy_o         <= 1'b1;
          shreg          <= {shreg[DATA_BUS_WIDTH-2:0], 1'b0};
          cnt            <= cnt - 1'b1;
          if (cnt == COUNTER_SIZE'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: a queue of expected (bit, cycle) pairs checked by a monitor.
module tb_serializer;
  import serdes_pkg::*;

  localparam int W = SERDES_DEFAULT_WIDTH;
  localparam int MW = $clog2(W);

  logic          clk = 1'b0;
  logic          arst_ni = 1'b0;
  logic [W-1:0]  data = '0;
  logic [MW-1:0] mod = '0;
  logic          dval = 1'b0;
  logic          ser, ser_val, busy;

  serializer #(.DATA_BUS_WIDTH(W)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .data_i(data), .data_mod_i(mod), .data_val_i(dval),
    .ser_data_o(ser), .ser_data_val_o(ser_val), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         b;
    int           at;
    logic         last;
    logic [W-1:0] word;
    int           len;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  int free_edge = 0, accepted = 0, words_seen = 0;
  logic [W-1:0] asm_word = '0;
  logic exp_val;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: a word occupies the line for len cycles starting one cycle after
  // acceptance, and the next acceptance is possible on the edge after its last bit.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [MW-1:0] m);
    int edge_n, len;
    @(negedge clk);
    dval = v; data = d; mod = m;
    edge_n = cyc + 1;
    if (v && edge_n >= free_edge) begin
      len = (m == 0) ? W : int'(m);
      for (int k = 0; k < len; k++)
        q.push_back('{b: d[W-1-k], at: edge_n + 1 + k, last: (k == len - 1), word: d, len: len});
      free_edge = edge_n + len + 1;
      accepted++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      drive_cycle(1'b0, '0, '0);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d bits outstanding, expected 0", q.size());
      q.delete();
    end
    repeat (2) drive_cycle(1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (arst_ni) begin
      exp_val = (q.size() > 0) && (q[0].at == cyc);
      check("ser_val", ser_val, exp_val);
      check("busy", busy, exp_val);
      if (!ser_val) check("idle_data", ser, 1'b0);
      if (exp_val) begin
        e = q.pop_front();
        if (ser_val) begin
          check("bit_value", ser, e.b);
          asm_word = {asm_word[W-2:0], ser};
        end
        if (e.last) begin
          check("word", asm_word, e.word >> (W - e.len));
          words_seen++;
          asm_word = '0;
        end
      end else if (q.size() > 0 && q[0].at < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL stale_entry: expected bit at cycle %0d, now %0d", q[0].at, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int target, n;
    #12;
    check("rst_data", ser, 1'b0);
    check("rst_val", ser_val, 1'b0);
    check("rst_busy", busy, 1'b0);
    #5 arst_ni = 1'b1;
    repeat (2) drive_cycle(1'b0, '0, '0);

    // Full word, then a short word
    drive_cycle(1'b1, 16'hA5C3, '0);
    wait_idle(40);
    drive_cycle(1'b1, 16'hF000, MW'(3));
    wait_idle(40);

    // Request during a word is dropped
    drive_cycle(1'b1, 16'h1234, '0);
    repeat (5) drive_cycle(1'b0, '0, '0);
    drive_cycle(1'b1, 16'hFFFF, '0);
    wait_idle(40);

    // Back-to-back: second word held until accepted at the first possible edge
    drive_cycle(1'b1, 16'h8001, '0);
    target = accepted + 1;
    n = 0;
    while (accepted < target && n < 40) begin
      drive_cycle(1'b1, 16'h7FFE, '0);
      n++;
    end
    check("b2b_accepted", accepted, target);
    wait_idle(40);

    // Asynchronous reset in the middle of a word
    drive_cycle(1'b1, 16'hFFFF, '0);
    repeat (8) drive_cycle(1'b0, '0, '0);
    #2 arst_ni = 1'b0;
    #1;
    check("arst_data", ser, 1'b0);
    check("arst_val", ser_val, 1'b0);
    check("arst_busy", busy, 1'b0);
    if (q.size() > 0) accepted--;
    q.delete();
    asm_word = '0;
    free_edge = 0;
    repeat (2) @(negedge clk);
    #2 arst_ni = 1'b1;
    repeat (6) drive_cycle(1'b0, '0, '0);
    drive_cycle(1'b1, 16'h00FF, '0);
    wait_idle(40);

    // Random full-width words with random requests while busy
    target = accepted + 1000;
    n = 0;
    while (accepted < target && n < 40000) begin
      drive_cycle(($urandom_range(0, 3) != 0), W'($urandom), '0);
      n++;
    end
    check("rand_full_count", accepted, target);
    wait_idle(40);

    // Random lengths
    target = accepted + 200;
    n = 0;
    while (accepted < target && n < 10000) begin
      drive_cycle(($urandom_range(0, 2) != 0), W'($urandom), MW'($urandom));
      n++;
    end
    check("rand_mod_count", accepted, target);
    wait_idle(40);

    check("word_count", words_seen, accepted);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
